// File: rtl/z_window_monitor.sv
// rtl/z_window_monitor.sv - windowed high-count / longest-run monitor for detector output Z
module z_window_monitor #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             z_in,
    output logic [CNT_W-1:0] win_count,
    output logic [CNT_W-1:0] max_run,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             dropped,
    input  logic             clr_dropped
);

    localparam int POS_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIN_LEN - 1);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t           state, state_nxt;
    logic             sample;
    logic [POS_W-1:0] pos;
    logic [CNT_W-1:0] ones, run, best;
    logic [CNT_W-1:0] z_ext, ones_nxt, run_nxt, best_nxt;
    logic             win_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // IDLE->COUNT takes sample 0 on the same edge, so sampling simply follows en.
    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = COUNT;
                    sample    = 1'b1;
                end
            end
            COUNT: begin
                if (en) sample    = 1'b1;
                else    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        z_ext    = {{(CNT_W-1){1'b0}}, z_in};
        ones_nxt = ones + z_ext;
        run_nxt  = z_in ? run + CNT_W'(1) : '0;
        best_nxt = (run_nxt > best) ? run_nxt : best;
        win_end  = sample && (pos == POS_LAST);
    end

    // Counters restart on window end so runs never cross a window boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            ones <= '0;
            run  <= '0;
            best <= '0;
        end else if (!sample || win_end) begin
            pos  <= '0;
            ones <= '0;
            run  <= '0;
            best <= '0;
        end else begin
            pos  <= pos + POS_W'(1);
            ones <= ones_nxt;
            run  <= run_nxt;
            best <= best_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
            max_run   <= '0;
            res_valid <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            if (win_end) begin
                if (!res_valid || res_ready) begin
                    win_count <= ones_nxt;
                    max_run   <= best_nxt;
                    res_valid <= 1'b1;
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (win_end && res_valid && !res_ready) dropped <= 1'b1;
            else if (clr_dropped)                   dropped <= 1'b0;
        end
    end

endmodule

// File: tb/tb_z_window_monitor.sv
// tb/tb_z_window_monitor.sv - randomized and directed bench for z_window_monitor
module tb_z_window_monitor;

    localparam int WIN_LEN = 4;
    localparam int CNT_W   = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             z_in = 1'b0;
    logic             res_ready = 1'b1;
    logic             clr_dropped = 1'b0;
    logic [CNT_W-1:0] win_count, max_run;
    logic             res_valid, dropped;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of samples in the current window plus the result register.
    int               win_q[$];
    logic [CNT_W-1:0] m_count = '0, m_run = '0;
    logic             m_valid = 1'b0, m_dropped = 1'b0;

    z_window_monitor #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .z_in(z_in),
        .win_count(win_count), .max_run(max_run), .res_valid(res_valid),
        .res_ready(res_ready), .dropped(dropped), .clr_dropped(clr_dropped)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        win_q.delete();
        m_count = '0; m_run = '0; m_valid = 1'b0; m_dropped = 1'b0;
    endtask

    // Drive one cycle's inputs, wait for the edge, advance the model, settle 1ns past the edge.
    task automatic step(input logic e, input logic z, input logic rdy, input logic clr);
        int cnt, longest, cur;
        logic push, lost;
        en = e; z_in = z; res_ready = rdy; clr_dropped = clr;
        @(posedge clk);
        push = 1'b0; lost = 1'b0; cnt = 0; longest = 0;
        if (e) begin
            win_q.push_back(int'(z));
            if (win_q.size() == WIN_LEN) begin
                cur = 0;
                foreach (win_q[i]) begin
                    cnt += win_q[i];
                    cur = win_q[i] ? cur + 1 : 0;
                    if (cur > longest) longest = cur;
                end
                push = 1'b1;
                win_q.delete();
            end
        end else begin
            win_q.delete();
        end
        if (push) begin
            if (!m_valid || rdy) begin
                m_count = CNT_W'(cnt); m_run = CNT_W'(longest); m_valid = 1'b1;
            end else begin
                lost = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (lost)     m_dropped = 1'b1;
        else if (clr) m_dropped = 1'b0;
        #1;
    endtask

    task automatic feed(input logic [3:0] bits, input logic rdy);
        for (int i = 0; i < 4; i++) step(1'b1, bits[3-i], rdy, 1'b0);
    endtask

    task automatic test_reset();
        n_tests++; if (win_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", win_count); end
        n_tests++; if (max_run   !== 3'd0) begin n_fail++; $display("FAIL reset_run got %0d want 0", max_run); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", res_valid); end
        n_tests++; if (dropped   !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b want 0", dropped); end
        rst_n = 1'b1;
        #1;
        feed(4'b1110, 1'b0);
        feed(4'b1111, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++; if (res_valid !== 1'b1 || dropped !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state got v=%b d=%b want 1/1", res_valid, dropped); end
        rst_n = 1'b0;
        #2;
        model_reset();
        n_tests++; if ({win_count, max_run, res_valid, dropped} !== 8'd0) begin n_fail++; $display("FAIL async_reset got %0d/%0d v=%b d=%b want all 0", win_count, max_run, res_valid, dropped); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        feed(4'b1011, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd3 || max_run !== 3'd2) begin n_fail++; $display("FAIL post_reset_window got v=%b %0d/%0d want 1 3/2", res_valid, win_count, max_run); end
    endtask

    task automatic test_basic();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1101, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd3 || max_run !== 3'd2) begin n_fail++; $display("FAIL basic_first got v=%b %0d/%0d want 1 3/2", res_valid, win_count, max_run); end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse got v=%b want 0", res_valid); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd4 || max_run !== 3'd4) begin n_fail++; $display("FAIL basic_full got v=%b %0d/%0d want 1 4/4", res_valid, win_count, max_run); end
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1000, 1'b0);
        feed(4'b0110, 1'b0);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd1 || max_run !== 3'd1 || dropped !== 1'b1) begin n_fail++; $display("FAIL bp_hold got v=%b %0d/%0d d=%b want 1 1/1 d=1", res_valid, win_count, max_run, dropped); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++; if (res_valid !== 1'b0 || dropped !== 1'b1) begin n_fail++; $display("FAIL bp_accept got v=%b d=%b want 0 1", res_valid, dropped); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL bp_clear got d=%b want 0", dropped); end
    endtask

    task automatic test_accept_load();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b1110, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd3 || max_run !== 3'd3) begin n_fail++; $display("FAIL al_held got v=%b %0d/%0d want 1 3/3", res_valid, win_count, max_run); end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd1 || max_run !== 3'd1 || dropped !== 1'b0) begin n_fail++; $display("FAIL al_swap got v=%b %0d/%0d d=%b want 1 1/1 d=0", res_valid, win_count, max_run, dropped); end
    endtask

    task automatic test_enable_abort();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_result got v=%b want 0", res_valid); end
        feed(4'b0001, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd1 || max_run !== 3'd1) begin n_fail++; $display("FAIL abort_fresh got v=%b %0d/%0d want 1 1/1", res_valid, win_count, max_run); end
    endtask

    task automatic test_boundary_run();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        feed(4'b0011, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd2 || max_run !== 3'd2) begin n_fail++; $display("FAIL bnd_first got v=%b %0d/%0d want 1 2/2", res_valid, win_count, max_run); end
        feed(4'b1100, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || win_count !== 3'd2 || max_run !== 3'd2) begin n_fail++; $display("FAIL bnd_second got v=%b %0d/%0d want 1 2/2", res_valid, win_count, max_run); end
    endtask

    task automatic test_random();
        logic e, z, r, c;
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 11) != 0);
            z = $urandom_range(0, 1) != 0;
            r = $urandom_range(0, 2) != 0;
            c = ($urandom_range(0, 7) == 0);
            step(e, z, r, c);
            n_tests++;
            if (res_valid !== m_valid || dropped !== m_dropped || win_count !== m_count || max_run !== m_run) begin
                n_fail++;
                $display("FAIL random[%0d] got v=%b d=%b %0d/%0d want v=%b d=%b %0d/%0d", i,
                         res_valid, dropped, win_count, max_run, m_valid, m_dropped, m_count, m_run);
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_accept_load();
        test_enable_abort();
        test_boundary_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z_window_monitor.md
# z_window_monitor

Downstream consumer of the sequence-detector output `Z`. It samples `z_in` every clock over back-to-back fixed-length windows. For each window it reports the number of high cycles and the longest run of consecutive high cycles. Results are held in a one-deep output register with a valid/ready handshake, and a sticky flag records any result lost to back-pressure.

## Interface
- `WIN_LEN`, default 16: window length in clock cycles; must be at least 2.
- `CNT_W`, default 5: result width; must satisfy `CNT_W >= $clog2(WIN_LEN+1)`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `en`, input, 1: monitor enable.
- `z_in`, input, 1: detector output `Z`, sampled every enabled cycle.
- `win_count`, output, `CNT_W`: number of high samples in the reported window.
- `max_run`, output, `CNT_W`: longest consecutive-high run in the reported window.
- `res_valid`, output, 1: result register holds an unconsumed result.
- `res_ready`, input, 1: consumer accepts the result.
- `dropped`, output, 1: sticky flag; set when a completed window could not be stored.
- `clr_dropped`, input, 1: synchronous clear of `dropped`.

## Operation
- FSM has two states.
  - IDLE: no sampling. Moves to COUNT on any edge where `en=1`; that same edge takes sample 0.
  - COUNT: one sample per edge. Moves to IDLE on any edge where `en=0`.
- Internal state: `pos` (0..`WIN_LEN`-1), `ones`, `run`, `best`.
- Per-sample update, with z = `z_in`:
  - `ones += z`
  - `run = z ? run+1 : 0`
  - `best = max(best, new run)`
- Window end: the edge where `pos = WIN_LEN-1`.
  - Final values include that last sample.
  - They are pushed to the output register on that edge.
  - `pos`, `ones`, `run` and `best` restart at 0 for the next window with no gap cycle.
  - Runs never span a window boundary.
- Output register push rules:
  - Register empty (`res_valid=0`): load, set `res_valid`.
  - Register full and `res_ready=1` on the same edge: accept the old result and load the new one; `res_valid` stays 1.
  - Register full and `res_ready=0`: keep the old result, discard the new one, set `dropped`.
- Handshake without a push: `res_valid & res_ready` on an edge clears `res_valid`. Data outputs hold their last values.
- `en` deasserted mid-window: partial window discarded, counters zeroed, state returns to IDLE. The output register and `dropped` are unaffected.
- `dropped`:
  - Set and `clr_dropped` on the same edge: set wins.
  - Otherwise `clr_dropped` clears it.
- Arithmetic is unsigned. Counts cannot exceed `WIN_LEN`, so no wrap is possible given the `CNT_W` rule.

## Timing
- Reset (`rst_n=0`, asynchronous) forces:
  - `win_count=0`, `max_run=0`, `res_valid=0`, `dropped=0`
  - FSM to IDLE
  - all internal counters to 0
- Reset asserted mid-window aborts the window.
- Reset release: the first enabled edge after release takes sample 0.
- Latency: results are visible immediately after the edge that samples the last bit of the window (0 extra cycles).
- Throughput: one window per `WIN_LEN` cycles, continuous while `en=1`.
- A result sits in the register for at least one cycle before it can be accepted, unless the same-edge accept-and-load case applies.
- `z_in` and `res_ready` are sampled on the rising edge. No combinational path exists from any input to any output.

## Test plan
Bench overrides `WIN_LEN=4`, `CNT_W=3`; `en=1` and `res_ready=1` unless stated.
- Reset: pulse `rst_n` low mid-window after 2 samples -> all outputs 0 at once. After release, the next 4 samples form a fresh window; `z` = 1,0,1,1 gives `win_count=3`, `max_run=2`.
- Basic windows: `z` = 1,1,0,1 then 1,1,1,1 -> first result 3/2 (one-cycle `res_valid` pulse), second result 4/4 (full-scale value).
- Back-pressure:
  - `res_ready=0`; `z` = 1,0,0,0 then 0,1,1,0 -> outputs hold 1/1, `dropped=1`.
  - Raise `res_ready` for one cycle -> `res_valid=0`.
  - Pulse `clr_dropped` -> `dropped=0`.
- Accept and load on the same edge: hold the first result unaccepted, assert `res_ready` exactly on the second window's last edge -> `res_valid` stays 1 and outputs switch to the second result.
- Enable abort: `en` low after 2 samples of 1,1 -> no result produced. Re-enable with `z` = 0,0,0,1 -> result 1/1 with no carry-over.
- Boundary run: `z` = 0,0,1,1 then 1,1,0,0 -> results 2/2 and 2/2, never a run of 4.
